// File: rtl/reflet_uart_rx_if.sv
// CPU-side port bundle of the Reflet UART receiver: FIFO read port, status and sticky error flags.
// The receiver is the slave; the UART register block (or a bench) is the master.
interface reflet_uart_rx_if #(
  parameter int fifo_depth = 4
);
  localparam int CW = $clog2(fifo_depth) + 1;

  logic          rd_en;
  logic          err_clear;
  logic [7:0]    data_out;
  logic          data_valid;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          overflow;
  logic          frame_err;
  logic          parity_err;

  modport master (
    output rd_en, err_clear,
    input  data_out, data_valid, fifo_count, busy, overflow, frame_err, parity_err
  );

  modport slave (
    input  rd_en, err_clear,
    output data_out, data_valid, fifo_count, busy, overflow, frame_err, parity_err
  );
endinterface

// File: rtl/reflet_uart_rx.sv
// Reflet UART receive front-end: rx synchronizer, 8N1 frame FSM and first-word-fall-through FIFO.
// Define REFLET_UART_RX_PARITY_EN for 8E1 framing with a sticky parity_err flag.
module reflet_uart_rx #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int fifo_depth = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  reflet_uart_rx_if.slave bus
);
  localparam int DIV  = clk_freq / baud_rate;
  localparam int CNTW = $clog2(DIV);
  localparam int AW   = $clog2(fifo_depth);
  localparam int CW   = AW + 1;
  localparam logic [CNTW-1:0] HALF_LOAD = CNTW'(DIV / 2 - 1);
  localparam logic [CNTW-1:0] FULL_LOAD = CNTW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  logic            sync1_q, sync1_d;
  logic            rxs_q, rxs_d;
  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      mem_q [fifo_depth];
  logic [7:0]      mem_d [fifo_depth];
  logic [CW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   rptr_q, rptr_d;
  logic            ovf_q, ovf_d;
  logic            ferr_q, ferr_d;
`ifdef REFLET_UART_RX_PARITY_EN
  logic            perr_q, perr_d;
  logic            perr_set;
`endif

  logic          tick;
  logic          push;
  logic          ferr_set;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          drop;

  always_comb begin
    sync1_d  = rx;
    rxs_d    = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef REFLET_UART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    tick = (cnt_q == '0);

    // All timed states share the down-counter; action happens on terminal count.
    if (state_q != S_IDLE && state_q != S_BREAK && !tick)
      cnt_d = cnt_q - CNTW'(1);

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (tick) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef REFLET_UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef REFLET_UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          perr_set = ^{shift_q, rxs_q};
          state_d  = S_STOP;
          cnt_d    = FULL_LOAD;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (rxs_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    count  = wptr_q - rptr_q;
    full   = (count == CW'(fifo_depth));
    empty  = (count == '0);
    pop    = bus.rd_en && !empty;
    drop   = push && full && !pop;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    // When full, a same-cycle pop frees the slot the write lands in.
    if (push && !drop) begin
      mem_d[wptr_q[AW-1:0]] = shift_q;
      wptr_d                = wptr_q + CW'(1);
    end
    if (pop) rptr_d = rptr_q + CW'(1);

    ovf_d  = drop     ? 1'b1 : (bus.err_clear ? 1'b0 : ovf_q);
    ferr_d = ferr_set ? 1'b1 : (bus.err_clear ? 1'b0 : ferr_q);
`ifdef REFLET_UART_RX_PARITY_EN
    perr_d = perr_set ? 1'b1 : (bus.err_clear ? 1'b0 : perr_q);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef REFLET_UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      rxs_q   <= rxs_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
`ifdef REFLET_UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.data_out   = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign bus.data_valid = !empty;
  assign bus.fifo_count = count;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.overflow   = ovf_q;
  assign bus.frame_err  = ferr_q;
`ifdef REFLET_UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_reflet_uart_rx.sv
// Bench for reflet_uart_rx: directed frames plus random traffic checked against a queue-based
// model of the receive FIFO and sticky flags.
module tb_reflet_uart_rx;
  localparam int DIV   = 104;
  localparam int DEPTH = 4;
`ifdef REFLET_UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // Posedge (counted from the start-bit negedge) at which the stop bit is sampled.
  localparam int STOP_EDGE = 3 + DIV / 2 + NBITS * DIV;

  logic clk;
  logic reset;
  logic rx;

  reflet_uart_rx_if #(.fifo_depth(DEPTH)) bus ();

  reflet_uart_rx #(
    .clk_freq  (1000000),
    .baud_rate (9600),
    .fifo_depth(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic       ovf_m;
  logic       fe_m;
  logic       pe_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low, input logic bad_par);
    rx = 1'b0;
    cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(DIV);
    end
`ifdef REFLET_UART_RX_PARITY_EN
    rx = (^b) ^ bad_par;
    cycles(DIV);
`endif
    if (stop_low > 0) begin
      rx = 1'b0;
      cycles(stop_low);
    end
    rx = 1'b1;
    cycles(DIV);
  endtask

  function automatic void model_frame(input logic [7:0] b, input logic stop_bad, input logic par_bad);
    if (stop_bad) begin
      fe_m = 1'b1;
    end else begin
      if (par_bad) pe_m = 1'b1;
      if (q.size() == DEPTH) ovf_m = 1'b1;
      else q.push_back(b);
    end
  endfunction

  task automatic clear_flags();
    bus.err_clear = 1'b1;
    cycles(1);
    bus.err_clear = 1'b0;
    ovf_m = 1'b0;
    fe_m  = 1'b0;
    pe_m  = 1'b0;
  endtask

  task automatic model_pop();
    if (q.size() > 0) begin
      check("head", bus.data_out, q[0]);
      void'(q.pop_front());
    end
    bus.rd_en = 1'b1;
    cycles(1);
    bus.rd_en = 1'b0;
  endtask

  task automatic check_all();
    check("fifo_count", bus.fifo_count, q.size());
    check("data_valid", bus.data_valid, q.size() != 0);
    if (q.size() > 0) check("data_out", bus.data_out, q[0]);
    check("overflow", bus.overflow, ovf_m);
    check("frame_err", bus.frame_err, fe_m);
    check("parity_err", bus.parity_err, pe_m);
    check("busy", bus.busy, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 2 * DIV) begin
      cycles(1);
      n++;
    end
    if (bus.busy) check("idle_timeout", bus.busy, 0);
  endtask

  task automatic drain();
    while (q.size() > 0) model_pop();
    check("drained_valid", bus.data_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [7:0] mid;
    int         kind;
    logic       sbad;
    logic       pbad;

    reset         = 1'b0;
    rx            = 1'b1;
    bus.rd_en     = 1'b0;
    bus.err_clear = 1'b0;
    ovf_m = 1'b0;
    fe_m  = 1'b0;
    pe_m  = 1'b0;
    cycles(5);
    check("rst_data_out", bus.data_out, 8'h00);
    check_all();
    reset = 1'b1;
    cycles(3);

    // Single frame, then pop.
    send_frame(8'h0E, 0, 1'b0);
    model_frame(8'h0E, 1'b0, 1'b0);
    check("t1_byte", bus.data_out, 8'h0E);
    check_all();
    model_pop();
    check_all();

    // Short glitch: false start.
    rx = 1'b0;
    cycles(10);
    check("glitch_busy", bus.busy, 1);
    cycles(10);
    rx = 1'b1;
    cycles(80);
    check_all();

    // Stop bit held low, then a clean frame, then clear.
    send_frame(8'h55, 300, 1'b0);
    model_frame(8'h55, 1'b1, 1'b0);
    check("ferr_set", bus.frame_err, 1);
    check_all();
    send_frame(8'hA3, 0, 1'b0);
    model_frame(8'hA3, 1'b0, 1'b0);
    check_all();
    clear_flags();
    check_all();
    drain();

    // Overflow: five bytes into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(b, 0, 1'b0);
      model_frame(b, 1'b0, 1'b0);
    end
    check("ovf_count", bus.fifo_count, 4);
    check("ovf_flag", bus.overflow, 1);
    check_all();
    clear_flags();
    check_all();

    // Push while full with a pop on the very same edge: no overflow.
    fork
      send_frame(8'h06, 0, 1'b0);
      begin
        repeat (STOP_EDGE - 1) @(negedge clk);
        check("samecyc_head", bus.data_out, q[0]);
        void'(q.pop_front());
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
      end
    join
    model_frame(8'h06, 1'b0, 1'b0);
    check("samecyc_ovf", bus.overflow, 0);
    check_all();
    drain();

    // Reset in the middle of data bit 4 discards both FIFO contents and the partial byte.
    send_frame(8'h11, 0, 1'b0);
    model_frame(8'h11, 1'b0, 1'b0);
    check_all();
    mid = 8'hB6;
    rx = 1'b0;
    cycles(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = mid[i];
      cycles(DIV);
    end
    rx = mid[4];
    cycles(DIV / 2);
    reset = 1'b0;
    rx    = 1'b1;
    cycles(4);
    q.delete();
    ovf_m = 1'b0;
    fe_m  = 1'b0;
    pe_m  = 1'b0;
    check("midrst_out", bus.data_out, 8'h00);
    check_all();
    reset = 1'b1;
    cycles(3);
    send_frame(8'h7F, 0, 1'b0);
    model_frame(8'h7F, 1'b0, 1'b0);
    check("post_rst_cnt", bus.fifo_count, 1);
    check_all();
    drain();

    // Back-to-back frames with a single stop bit.
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_frame(b, 0, 1'b0);
      model_frame(b, 1'b0, 1'b0);
    end
    check_all();
    drain();

`ifdef REFLET_UART_RX_PARITY_EN
    send_frame(8'h03, 0, 1'b0);
    model_frame(8'h03, 1'b0, 1'b0);
    check("par_ok", bus.parity_err, 0);
    check_all();
    send_frame(8'h03, 0, 1'b1);
    model_frame(8'h03, 1'b0, 1'b1);
    check("par_bad", bus.parity_err, 1);
    check_all();
    clear_flags();
    drain();
`endif

    // Random traffic with random reads, bad stop bits and clears.
    for (int it = 0; it < 30; it++) begin
      b    = 8'($urandom);
      kind = int'($urandom_range(0, 9));
      sbad = (kind == 0);
`ifdef REFLET_UART_RX_PARITY_EN
      pbad = (kind == 1);
`else
      pbad = 1'b0;
`endif
      send_frame(b, sbad ? int'($urandom_range(DIV, 3 * DIV)) : 0, pbad);
      model_frame(b, sbad, pbad);
      wait_idle();
      check_all();
      repeat ($urandom_range(0, 3)) model_pop();
      if ($urandom_range(0, 3) == 0) clear_flags();
      check_all();
      cycles(int'($urandom_range(0, 20)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
